mdio_phy_responder: RTL and testbench
=====================================

Name: mdio_phy_responder

Overview:
- Clause 22 MDIO target (PHY-side management responder); the far end of the MAC's MDIO master connection.
- Used in the WireShark bench and loopback builds to stand in for the external PHY.
- Decodes read and write frames from mdc/mdio, holds a small 16-bit register file, and answers reads by driving mdio through an active-low output enable.
- Write events are also exported to fabric logic.

Parameters:
- PHY_ADDR, 5'd1, PHYAD this target answers to.
- NUM_REGS, 8, number of implemented registers (addresses 0..NUM_REGS-1); range 4..32.
- PHY_ID1, 16'h0141, read-only value at register 2.
- PHY_ID2, 16'h0CC2, read-only value at register 3.
- SYNC_STAGES, 2, flops in the mdc and mdio_in synchronizers; minimum 2.

Ports:
- clk_clk  in  1  system clock; must be at least 8x mdc frequency.
- reset_reset  in  1  asynchronous, active-high reset.
- mdio_mdc  in  1  management clock from the master; asynchronous to clk_clk.
- mdio_mdio_in  in  1  resolved mdio line.
- mdio_mdio_out  out  1  data driven onto mdio when enabled.
- mdio_mdio_oen  out  1  output enable, active low; 1 = tristate.
- reg_wr_valid  out  1  one-cycle pulse on a completed write addressed to PHY_ADDR.
- reg_wr_addr  out  5  REGAD of that write.
- reg_wr_data  out  16  data of that write.
- frame_err  out  1  one-cycle pulse on an illegal ST or OP.

Behaviour:
- Reset values: mdio_mdio_out=1, mdio_mdio_oen=1, reg_wr_valid=0, reg_wr_addr=0, reg_wr_data=0, frame_err=0, all RW registers 0, FSM=PREAMBLE, preamble count 0.
- Reset is asynchronous. Asserting it mid-frame releases the bus immediately and the frame is lost.
- Sampling:
  - mdc and mdio_in each pass through SYNC_STAGES flops.
  - A rise event is a synced mdc 0->1; a fall event is 1->0.
  - Input bits are sampled only on rise events.
  - Outputs change only on the clk_clk cycle after a fall event.
- FSM states: PREAMBLE, ST, OP, PHYAD, REGAD, TA, DATA, SKIP.
- PREAMBLE:
  - Counts consecutive 1s, saturating at 32; any 0 with count<32 clears the count.
  - A 0 seen with count==32 is the first ST bit; go to ST.
- ST: next bit must be 1, else pulse frame_err and return to PREAMBLE with count 0.
- OP: 2 bits. 10 = read, 01 = write; 00 or 11 pulses frame_err and returns to PREAMBLE.
- PHYAD: 5 bits, MSB first. On mismatch with PHY_ADDR, finish REGAD, then go to SKIP.
- SKIP: counts 18 rise events (TA + data) without driving, then returns to PREAMBLE with count 0.
- REGAD: 5 bits, MSB first.
  - On a read, latch read data on the last REGAD bit:
    - reg 2 -> PHY_ID1.
    - reg 3 -> PHY_ID2.
    - addr >= NUM_REGS -> 16'h0000.
    - otherwise the register contents.
- TA (read):
  - Stay tristate through the first TA bit.
  - On the fall event after the first TA rise, drive oen=0, out=0.
- DATA (read):
  - On each following fall event, present the next data bit, MSB first.
  - On the fall event after the 16th data rise, set oen=1, out=1, then go to PREAMBLE.
- TA/DATA (write):
  - TA bits are sampled and not checked.
  - Data is shifted in MSB first.
  - The cycle after the 16th data rise: reg_wr_valid=1 for exactly one clk_clk cycle; reg_wr_addr and reg_wr_data hold until the next write.
  - The register is updated only if addr < NUM_REGS and addr is not 2 or 3.
- After any completed frame, the preamble count restarts at 0; 32 fresh 1s are required.
- Back-to-back frames: none may start until the previous frame's release has occurred.
- mdc glitches shorter than SYNC_STAGES clk_clk cycles are not required to be filtered.

Optional Feature:
- Macro MDIO_PREAMBLE_SUPPRESS_EN.
- Defined:
  - After at least one completed frame addressed to PHY_ADDR, a 0 following 1 or more 1s is accepted as ST start (preamble suppression).
  - The very first frame after reset still needs 32 ones.
- Undefined: a full 32-bit preamble is always required.

Test Plan:
- Write, then read back: 32x1, write PHYAD=1 REGAD=0 data=16'hA55A -> reg_wr_valid pulses once with addr=0 and data=A55A. A subsequent read of reg 0 drives TA bit2=0, then A55A MSB first; oen=0 for exactly 17 mdc periods.
- ID read: read reg 2 -> 0141; read reg 3 -> 0CC2. Then write 16'hFFFF to reg 3 -> reg_wr_valid pulses, and a re-read still returns 0CC2.
- Wrong address: read with PHYAD=5 -> oen stays 1 for the whole frame. A following correct read of reg 0 succeeds.
- Bad opcode: OP=11 -> frame_err one-cycle pulse, no drive. A following 32x1 write frame is accepted.
- Short preamble: 31 ones then a read -> ignored, no drive (macro undefined). With the macro defined, after a prior good frame, a read with 4 ones is answered.
- Reset mid-read: assert reset_reset during data bit 7 -> oen=1 and out=1 asynchronously, and no reg_wr_valid. The next full frame is decoded correctly.

Source files
------------

// File: rtl/mdio_phy_responder.sv
// Clause 22 MDIO target standing in for an external PHY: decodes mdc/mdio frames and serves a small register file.
// Define MDIO_PREAMBLE_SUPPRESS_EN to accept suppressed preambles after the first good frame addressed to this PHY.
module mdio_phy_responder #(
  parameter logic [4:0]  PHY_ADDR    = 5'd1,
  parameter int          NUM_REGS    = 8,
  parameter logic [15:0] PHY_ID1     = 16'h0141,
  parameter logic [15:0] PHY_ID2     = 16'h0CC2,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        mdio_mdc,
  input  logic        mdio_mdio_in,
  output logic        mdio_mdio_out,
  output logic        mdio_mdio_oen,
  output logic        reg_wr_valid,
  output logic [4:0]  reg_wr_addr,
  output logic [15:0] reg_wr_data,
  output logic        frame_err
);

  localparam logic [2:0] S_PREAMBLE = 3'd0, S_ST = 3'd1, S_OP = 3'd2, S_PHYAD = 3'd3,
                         S_REGAD = 3'd4, S_TA = 3'd5, S_DATA = 3'd6, S_SKIP = 3'd7;

  logic [SYNC_STAGES-1:0] mdc_sync, mdio_sync;
  logic        mdc_prev, mdc_s, bit_in, rise, fall, st_ok, write_commit;
  logic [2:0]  state;
  logic [5:0]  pre_cnt;
  logic [4:0]  bit_cnt;
  logic        is_read, op_first, addr_match;
  logic [3:0]  phyad_sh;
  logic [4:0]  regad_sh, phyad_next, regad_next;
  logic [15:0] shift_reg, rd_word, wr_word;
  logic [15:0] regs [NUM_REGS];

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      mdc_sync  <= '0;
      mdio_sync <= '0;
      mdc_prev  <= 1'b0;
    end else begin
      mdc_sync  <= {mdc_sync[SYNC_STAGES-2:0], mdio_mdc};
      mdio_sync <= {mdio_sync[SYNC_STAGES-2:0], mdio_mdio_in};
      mdc_prev  <= mdc_s;
    end
  end

  assign mdc_s      = mdc_sync[SYNC_STAGES-1];
  assign bit_in     = mdio_sync[SYNC_STAGES-1];
  assign rise       = mdc_s & ~mdc_prev;
  assign fall       = ~mdc_s & mdc_prev;
  assign phyad_next = {phyad_sh, bit_in};
  assign regad_next = {regad_sh[3:0], bit_in};
  assign wr_word    = {shift_reg[14:0], bit_in};
  assign write_commit = rise && (state == S_DATA) && !is_read && (bit_cnt == 5'd15);

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  logic supp_ok, frame_done;
  assign frame_done = write_commit || (fall && (state == S_DATA) && is_read && (bit_cnt == 5'd16));
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset)     supp_ok <= 1'b0;
    else if (frame_done) supp_ok <= 1'b1;
  end
  assign st_ok = (pre_cnt == 6'd32) || (supp_ok && (pre_cnt != 6'd0));
`else
  assign st_ok = (pre_cnt == 6'd32);
`endif

  // Read data is selected from the REGAD value completed by the current bit.
  always_comb begin
    rd_word = 16'h0000;
    for (int i = 0; i < NUM_REGS; i++)
      if (regad_next == 5'(i)) rd_word = regs[i];
    if (regad_next == 5'd2) rd_word = PHY_ID1;
    if (regad_next == 5'd3) rd_word = PHY_ID2;
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 16'h0000;
    end else if (write_commit) begin
      for (int i = 0; i < NUM_REGS; i++)
        if ((regad_sh == 5'(i)) && (i != 2) && (i != 3)) regs[i] <= wr_word;
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state         <= S_PREAMBLE;
      pre_cnt       <= 6'd0;
      bit_cnt       <= 5'd0;
      is_read       <= 1'b0;
      op_first      <= 1'b0;
      addr_match    <= 1'b0;
      phyad_sh      <= 4'd0;
      regad_sh      <= 5'd0;
      shift_reg     <= 16'h0000;
      mdio_mdio_out <= 1'b1;
      mdio_mdio_oen <= 1'b1;
      reg_wr_valid  <= 1'b0;
      reg_wr_addr   <= 5'd0;
      reg_wr_data   <= 16'h0000;
      frame_err     <= 1'b0;
    end else begin
      reg_wr_valid <= 1'b0;
      frame_err    <= 1'b0;
      if (rise) begin
        case (state)
          S_PREAMBLE:
            if (bit_in) begin
              if (pre_cnt != 6'd32) pre_cnt <= pre_cnt + 6'd1;
            end else if (st_ok) begin
              state   <= S_ST;
              pre_cnt <= 6'd0;
            end else begin
              pre_cnt <= 6'd0;
            end
          S_ST:
            if (bit_in) begin
              state   <= S_OP;
              bit_cnt <= 5'd0;
            end else begin
              frame_err <= 1'b1;
              state     <= S_PREAMBLE;
              pre_cnt   <= 6'd0;
            end
          S_OP:
            if (bit_cnt == 5'd0) begin
              op_first <= bit_in;
              bit_cnt  <= 5'd1;
            end else if (op_first != bit_in) begin
              is_read <= op_first;
              state   <= S_PHYAD;
              bit_cnt <= 5'd0;
            end else begin
              frame_err <= 1'b1;
              state     <= S_PREAMBLE;
              pre_cnt   <= 6'd0;
              bit_cnt   <= 5'd0;
            end
          S_PHYAD: begin
            phyad_sh <= phyad_next[3:0];
            if (bit_cnt == 5'd4) begin
              addr_match <= (phyad_next == PHY_ADDR);
              state      <= S_REGAD;
              bit_cnt    <= 5'd0;
            end else bit_cnt <= bit_cnt + 5'd1;
          end
          S_REGAD: begin
            regad_sh <= regad_next;
            if (bit_cnt == 5'd4) begin
              bit_cnt <= 5'd0;
              if (is_read) shift_reg <= rd_word;
              state <= addr_match ? S_TA : S_SKIP;
            end else bit_cnt <= bit_cnt + 5'd1;
          end
          S_TA:
            if (bit_cnt == 5'd1) begin
              state   <= S_DATA;
              bit_cnt <= 5'd0;
            end else bit_cnt <= bit_cnt + 5'd1;
          S_DATA:
            if (is_read) begin
              if (bit_cnt != 5'd16) bit_cnt <= bit_cnt + 5'd1;
            end else begin
              shift_reg <= wr_word;
              if (bit_cnt == 5'd15) begin
                reg_wr_valid <= 1'b1;
                reg_wr_addr  <= regad_sh;
                reg_wr_data  <= wr_word;
                state        <= S_PREAMBLE;
                pre_cnt      <= 6'd0;
                bit_cnt      <= 5'd0;
              end else bit_cnt <= bit_cnt + 5'd1;
            end
          default:
            if (bit_cnt == 5'd17) begin
              state   <= S_PREAMBLE;
              pre_cnt <= 6'd0;
              bit_cnt <= 5'd0;
            end else bit_cnt <= bit_cnt + 5'd1;
        endcase
      end else if (fall) begin
        // The master samples on rising mdc, so read data is launched on falling mdc.
        if ((state == S_TA) && is_read && (bit_cnt == 5'd1)) begin
          mdio_mdio_oen <= 1'b0;
          mdio_mdio_out <= 1'b0;
        end else if ((state == S_DATA) && is_read) begin
          if (bit_cnt == 5'd16) begin
            mdio_mdio_oen <= 1'b1;
            mdio_mdio_out <= 1'b1;
            state         <= S_PREAMBLE;
            pre_cnt       <= 6'd0;
            bit_cnt       <= 5'd0;
          end else begin
            mdio_mdio_out <= shift_reg[15];
            shift_reg     <= {shift_reg[14:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Scoreboard bench for mdio_phy_responder: a bit-banged MDIO master plus a small register-file model.
module tb_mdio_phy_responder;

  localparam int HALF = 80;
  localparam logic [1:0] RD = 2'b10, WR = 2'b01;

  logic        clk_clk = 1'b0;
  logic        reset_reset, mdio_mdc, master_oe, master_bit, mdio_line;
  logic        mdio_mdio_out, mdio_mdio_oen, reg_wr_valid, frame_err;
  logic [4:0]  reg_wr_addr;
  logic [15:0] reg_wr_data;

  int vectors = 0, miscompares = 0, err_pulses = 0;
  logic [20:0] wr_q [$];
  logic [15:0] rd_q [$];
  logic [15:0] model_regs [32];
  logic        model_supp;

  assign mdio_line = master_oe ? master_bit : (mdio_mdio_oen ? 1'b1 : mdio_mdio_out);

  mdio_phy_responder dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .mdio_mdc(mdio_mdc),
    .mdio_mdio_in(mdio_line), .mdio_mdio_out(mdio_mdio_out), .mdio_mdio_oen(mdio_mdio_oen),
    .reg_wr_valid(reg_wr_valid), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .frame_err(frame_err)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Write-event side of the scoreboard: every reg_wr_valid cycle must match a queued write.
  always @(negedge clk_clk) begin
    if (reg_wr_valid === 1'b1) begin
      if (wr_q.size() == 0) checkOutput("wr_unexpected", 32'(reg_wr_valid), 32'd0);
      else checkOutput("wr_addr_data", {11'd0, reg_wr_addr, reg_wr_data}, {11'd0, wr_q.pop_front()});
    end
    if (frame_err === 1'b1) err_pulses++;
  end

  function automatic logic [15:0] model_read(input logic [4:0] a);
    if (a == 5'd2) return 16'h0141;
    if (a == 5'd3) return 16'h0CC2;
    if (a >= 5'd8) return 16'h0000;
    return model_regs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model_regs[i] = 16'h0000;
    model_supp = 1'b0;
  endtask

  task automatic mdc_cycle(input logic drive, input logic b, output logic smp, output logic oe);
    master_oe  = drive;
    master_bit = b;
    #(HALF);
    smp = mdio_line;
    oe  = mdio_mdio_oen;
    if (drive) checkOutput("bus_contention", 32'(mdio_mdio_oen), 32'd1);
    mdio_mdc = 1'b1;
    #(HALF);
    mdio_mdc = 1'b0;
  endtask

  task automatic applyStimulus(input string name, input int pre_len, input logic [1:0] st,
                               input logic [1:0] op, input logic [4:0] phyad, input logic [4:0] regad,
                               input logic [15:0] wdata, input int rst_bit);
    logic smp, oe, pre_ok, st_start, op_ok, accepted, expect_err, aborted, ta2;
    logic [15:0] rdata;
    int oen_low, err0;
    rdata = 16'h0; oen_low = 0; ta2 = 1'b1; aborted = 1'b0; err0 = err_pulses;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    pre_ok = (pre_len >= 32) || (model_supp && pre_len >= 1);
`else
    pre_ok = (pre_len >= 32);
`endif
    op_ok      = (op == RD) || (op == WR);
    st_start   = pre_ok && !st[1];
    expect_err = st_start && (!st[0] || !op_ok);
    accepted   = st_start && st[0] && op_ok && (phyad == 5'd1);
    if (accepted && rst_bit < 0) begin
      if (op == WR) begin
        wr_q.push_back({regad, wdata});
        if (regad < 5'd8 && regad != 5'd2 && regad != 5'd3) model_regs[regad] = wdata;
      end else rd_q.push_back(model_read(regad));
    end
    for (int i = 0; i < pre_len; i++) begin mdc_cycle(1'b1, 1'b1, smp, oe); if (!oe) oen_low++; end
    for (int i = 1; i >= 0; i--) begin mdc_cycle(1'b1, st[i], smp, oe); if (!oe) oen_low++; end
    if (st == 2'b01) begin
      for (int i = 1; i >= 0; i--) begin mdc_cycle(1'b1, op[i], smp, oe); if (!oe) oen_low++; end
      if (op_ok) begin
        for (int i = 4; i >= 0; i--) begin mdc_cycle(1'b1, phyad[i], smp, oe); if (!oe) oen_low++; end
        for (int i = 4; i >= 0; i--) begin mdc_cycle(1'b1, regad[i], smp, oe); if (!oe) oen_low++; end
        if (op == WR) begin
          mdc_cycle(1'b1, 1'b1, smp, oe);
          mdc_cycle(1'b1, 1'b0, smp, oe);
          for (int i = 15; i >= 0; i--) begin mdc_cycle(1'b1, wdata[i], smp, oe); if (!oe) oen_low++; end
        end else begin
          for (int i = 0; i < 18; i++) begin
            if (rst_bit >= 0 && i == 2 + rst_bit) begin
              master_oe = 1'b0;
              #(HALF);
              mdio_mdc = 1'b1;
              #(HALF/2);
              checkOutput({name, "_oen_before_reset"}, 32'(mdio_mdio_oen), 32'd0);
              reset_reset = 1'b1;
              #1;
              checkOutput({name, "_oen_in_reset"}, 32'(mdio_mdio_oen), 32'd1);
              checkOutput({name, "_out_in_reset"}, 32'(mdio_mdio_out), 32'd1);
              #(HALF/2 - 1);
              mdio_mdc = 1'b0;
              #33;
              reset_reset = 1'b0;
              model_reset();
              aborted = 1'b1;
              break;
            end
            mdc_cycle(1'b0, 1'b1, smp, oe);
            if (!oe) oen_low++;
            if (i == 1) ta2 = smp;
            if (i >= 2) rdata = {rdata[14:0], smp};
          end
        end
      end
    end
    master_oe = 1'b0;
    if (aborted) return;
    if (accepted) model_supp = 1'b1;
    checkOutput({name, "_oen_low_periods"}, 32'(oen_low), (accepted && op == RD) ? 32'd17 : 32'd0);
    checkOutput({name, "_frame_err"}, 32'(err_pulses - err0), expect_err ? 32'd1 : 32'd0);
    checkOutput({name, "_wr_seen"}, 32'(wr_q.size()), 32'd0);
    if (accepted && op == RD) begin
      checkOutput({name, "_ta2"}, 32'(ta2), 32'd0);
      if (rd_q.size() != 0) checkOutput({name, "_rd_data"}, 32'(rdata), 32'(rd_q.pop_front()));
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset_reset = 1'b1; mdio_mdc = 1'b0; master_oe = 1'b0; master_bit = 1'b1;
    model_reset();
    #27;
    checkOutput("reset_out", 32'(mdio_mdio_out), 32'd1);
    checkOutput("reset_oen", 32'(mdio_mdio_oen), 32'd1);
    checkOutput("reset_wr_valid", 32'(reg_wr_valid), 32'd0);
    checkOutput("reset_wr_addr", 32'(reg_wr_addr), 32'd0);
    checkOutput("reset_wr_data", 32'(reg_wr_data), 32'd0);
    checkOutput("reset_frame_err", 32'(frame_err), 32'd0);
    reset_reset = 1'b0;
    #76;

    applyStimulus("rd0_init", 32, 2'b01, RD, 5'd1, 5'd0, 16'h0, -1);
    applyStimulus("wr0", 32, 2'b01, WR, 5'd1, 5'd0, 16'hA55A, -1);
    checkOutput("wr0_addr_hold", 32'(reg_wr_addr), 32'd0);
    checkOutput("wr0_data_hold", 32'(reg_wr_data), 32'h0000A55A);
    applyStimulus("rd0", 32, 2'b01, RD, 5'd1, 5'd0, 16'h0, -1);
    applyStimulus("rd_id1", 32, 2'b01, RD, 5'd1, 5'd2, 16'h0, -1);
    applyStimulus("rd_id2", 32, 2'b01, RD, 5'd1, 5'd3, 16'h0, -1);
    applyStimulus("wr_id2", 32, 2'b01, WR, 5'd1, 5'd3, 16'hFFFF, -1);
    applyStimulus("rd_id2_again", 32, 2'b01, RD, 5'd1, 5'd3, 16'h0, -1);
    applyStimulus("wr7", 32, 2'b01, WR, 5'd1, 5'd7, 16'hBEEF, -1);
    applyStimulus("rd7", 32, 2'b01, RD, 5'd1, 5'd7, 16'h0, -1);
    applyStimulus("wr9", 32, 2'b01, WR, 5'd1, 5'd9, 16'h1234, -1);
    checkOutput("wr9_addr_hold", 32'(reg_wr_addr), 32'd9);
    checkOutput("wr9_data_hold", 32'(reg_wr_data), 32'h00001234);
    applyStimulus("rd9", 32, 2'b01, RD, 5'd1, 5'd9, 16'h0, -1);
    applyStimulus("rd_wrong_phy", 32, 2'b01, RD, 5'd5, 5'd0, 16'h0, -1);
    applyStimulus("rd0_after_skip", 32, 2'b01, RD, 5'd1, 5'd0, 16'h0, -1);
    applyStimulus("bad_op", 32, 2'b01, 2'b11, 5'd1, 5'd0, 16'h0, -1);
    applyStimulus("wr1", 32, 2'b01, WR, 5'd1, 5'd1, 16'h1357, -1);
    applyStimulus("rd1", 32, 2'b01, RD, 5'd1, 5'd1, 16'h0, -1);
    applyStimulus("bad_st", 32, 2'b00, RD, 5'd1, 5'd0, 16'h0, -1);
    applyStimulus("rd_pre31", 31, 2'b01, RD, 5'd1, 5'd1, 16'h0, -1);
    applyStimulus("rd_pre4", 4, 2'b01, RD, 5'd1, 5'd1, 16'h0, -1);
    applyStimulus("rd0_reset", 32, 2'b01, RD, 5'd1, 5'd0, 16'h0, 7);
    checkOutput("post_reset_wr_addr", 32'(reg_wr_addr), 32'd0);
    checkOutput("post_reset_wr_data", 32'(reg_wr_data), 32'd0);
    applyStimulus("rd0_post_reset", 32, 2'b01, RD, 5'd1, 5'd0, 16'h0, -1);
    applyStimulus("wr0_post_reset", 32, 2'b01, WR, 5'd1, 5'd0, 16'h0F0F, -1);
    applyStimulus("rd0_final", 32, 2'b01, RD, 5'd1, 5'd0, 16'h0, -1);
    #200;
    checkOutput("wr_queue_drained", 32'(wr_q.size()), 32'd0);
    checkOutput("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
